// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the PC, issues one imem read per cycle and queues the
// returned words with their PCs. Define FETCH_PERF_EN to add the bubble_count port.
module fetch_queue #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       bubble_count
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
   logic [CntW:0]     used;
   logic              push, pop;

   // Credit counts the outstanding response; a same-cycle pop does not free a slot.
   assign used       = {1'b0, count_q} + (CntW + 1)'(inflight_q);
   assign imem_req   = reset && !redirect_valid && (used < (CntW + 1)'(DEPTH));
   assign imem_addr  = pc_q;
   assign inst_valid = (count_q != '0) && !redirect_valid;
   assign inst_data  = mem_data_q[head_q];
   assign inst_pc    = mem_pc_q[head_q];
   assign push       = inflight_q && !redirect_valid;
   assign pop        = inst_valid && inst_ready;

   always_comb begin
      pc_d    = pc_q;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         if (imem_req) pc_d = pc_q + ADDR_W'(4);
         if (push) tail_d = tail_q + PtrW'(1);
         if (pop) head_d = head_q + PtrW'(1);
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data_q[i] <= '0;
            mem_pc_q[i]   <= '0;
         end
      end else begin
         pc_q          <= pc_d;
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         inflight_q    <= imem_req;
         inflight_pc_q <= pc_q;
         if (push) begin
            mem_data_q[tail_q] <= imem_rdata;
            mem_pc_q[tail_q]   <= inflight_pc_q;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] bubble_q;

   // Starved cycles: consumer ready but nothing to hand over; saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_q <= '0;
      end else if (inst_ready && !inst_valid && (bubble_q != '1)) begin
         bubble_q <= bubble_q + 32'd1;
      end
   end

   assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand-written reset/perf sequences.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] bubble_count;
`endif

   int total = 0;
   int bad   = 0;

   fetch_queue dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
      ,
      .bubble_count   (bubble_count)
`endif
   );

   always #5 clk = ~clk;

   // ROM with one-cycle read latency: word at a = 0x1000_0000 + a/4.
   logic [31:0] rom_q;
   always @(posedge clk) rom_q <= 32'h1000_0000 + (imem_addr >> 2);
   assign imem_rdata = rom_q;

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        chk_head;
      logic [31:0] e_pc;
      logic [31:0] e_data;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rst_n, logic rdy, logic redir, logic [31:0] rpc,
                               logic e_req, logic [31:0] e_addr, logic e_valid,
                               logic [31:0] e_pc, logic [31:0] e_data);
      vec_t v;
      v.rst_n    = rst_n;
      v.rdy      = rdy;
      v.redir    = redir;
      v.rpc      = rpc;
      v.e_req    = e_req;
      v.e_addr   = e_addr;
      v.e_valid  = e_valid;
      v.chk_head = e_valid || !rst_n;
      v.e_pc     = e_pc;
      v.e_data   = e_data;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic add_reset();
      vq.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
   endtask

   initial begin
      reset          = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Streaming from reset, then redirect to 0x100 with ready high and a non-empty FIFO.
      add_reset();
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h0,   0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h4,   0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h8,   1, 32'h0,   32'h1000_0000));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'hC,   1, 32'h4,   32'h1000_0001));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h10,  1, 32'h8,   32'h1000_0002));
      vq.push_back(mk(1, 1, 1, 32'h100,  0, 32'h14,  0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h100, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h104, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h108, 1, 32'h100, 32'h1000_0040));
      vq.push_back(mk(1, 1, 0, 0,        1, 32'h10C, 1, 32'h104, 32'h1000_0041));
      // Backpressure: fill to four entries, then drain and resume at 0x10.
      add_reset();
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h0,  0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h4,  0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h8,  1, 32'h0,  32'h1000_0000));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'hC,  1, 32'h0,  32'h1000_0000));
      vq.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h0,  32'h1000_0000));
      vq.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h0,  32'h1000_0000));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h10, 1, 32'h0,  32'h1000_0000));
      vq.push_back(mk(1, 1, 0, 0, 1, 32'h10, 1, 32'h4,  32'h1000_0001));
      vq.push_back(mk(1, 1, 0, 0, 1, 32'h14, 1, 32'h8,  32'h1000_0002));
      vq.push_back(mk(1, 1, 0, 0, 1, 32'h18, 1, 32'hC,  32'h1000_0003));
      vq.push_back(mk(1, 1, 0, 0, 1, 32'h1C, 1, 32'h10, 32'h1000_0004));
      // Redirect with three entries queued and one in flight.
      add_reset();
      vq.push_back(mk(1, 0, 0, 0,       1, 32'h0,   0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0,       1, 32'h4,   0, 0, 0));
      vq.push_back(mk(1, 0, 0, 0,       1, 32'h8,   1, 32'h0,   32'h1000_0000));
      vq.push_back(mk(1, 0, 0, 0,       1, 32'hC,   1, 32'h0,   32'h1000_0000));
      vq.push_back(mk(1, 0, 1, 32'h100, 0, 32'h10,  0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,       1, 32'h100, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,       1, 32'h104, 0, 0, 0));
      vq.push_back(mk(1, 1, 0, 0,       1, 32'h108, 1, 32'h100, 32'h1000_0040));
      vq.push_back(mk(1, 1, 0, 0,       1, 32'h10C, 1, 32'h104, 32'h1000_0041));

      foreach (vq[i]) begin
         @(negedge clk);
         reset          = vq[i].rst_n;
         inst_ready     = vq[i].rdy;
         redirect_valid = vq[i].redir;
         redirect_pc    = vq[i].rpc;
         #1;
         check($sformatf("v%0d.req", i),   32'(imem_req),   32'(vq[i].e_req));
         check($sformatf("v%0d.addr", i),  imem_addr,       vq[i].e_addr);
         check($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(vq[i].e_valid));
         if (vq[i].chk_head) begin
            check($sformatf("v%0d.pc", i),   inst_pc,   vq[i].e_pc);
            check($sformatf("v%0d.data", i), inst_data, vq[i].e_data);
         end
      end

      // Asynchronous reset asserted between edges while streaming.
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async.req",   32'(imem_req),   32'h0);
      check("async.addr",  imem_addr,       32'h0);
      check("async.valid", 32'(inst_valid), 32'h0);
      check("async.pc",    inst_pc,         32'h0);
      check("async.data",  inst_data,       32'h0);
`ifdef FETCH_PERF_EN
      check("async.bubble", bubble_count, 32'd0);
`endif
      @(negedge clk);
      reset      = 1'b1;
      inst_ready = 1'b1;
      #1;
      check("rel.c1.req",  32'(imem_req), 32'h1);
      check("rel.c1.addr", imem_addr,     32'h0);
      @(negedge clk);
      #1;
      check("rel.c2.valid", 32'(inst_valid), 32'h0);
      @(negedge clk);
      #1;
      check("rel.c3.valid", 32'(inst_valid), 32'h1);
      check("rel.c3.pc",    inst_pc,         32'h0);
      check("rel.c3.data",  inst_data,       32'h1000_0000);
`ifdef FETCH_PERF_EN
      check("perf.first", bubble_count, 32'd2);
`endif
      @(negedge clk);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      check("redir2.valid", 32'(inst_valid), 32'h0);
`ifdef FETCH_PERF_EN
      check("perf.redir.base", bubble_count, 32'd2);
`endif
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("redir2.addr", imem_addr, 32'h200);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("redir2.valid3", 32'(inst_valid), 32'h1);
      check("redir2.pc",     inst_pc,         32'h200);
      check("redir2.data",   inst_data,       32'h1000_0080);
`ifdef FETCH_PERF_EN
      check("perf.redir", bubble_count, 32'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end that sits directly upstream of the `Processor` decode/execute path. It owns the program counter and issues one instruction-memory read per cycle. It buffers returned words with their PCs in a small FIFO and hands them to the consumer over a valid/ready handshake. A redirect input (branch/jump target) flushes all buffered and in-flight work and restarts fetch at a new address.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `DATA_W`, 32, instruction word width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  ADDR_W  read address, valid when `imem_req`=1
- `imem_rdata`  in  DATA_W  read data; valid the cycle after its request
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  ADDR_W  restart address, sampled when `redirect_valid`=1
- `inst_valid`  out  1  head entry available
- `inst_ready`  in  1  consumer accepts head
- `inst_data`  out  DATA_W  head instruction word
- `inst_pc`  out  ADDR_W  PC of head instruction
- `bubble_count`  out  32  starved-cycle counter (only with `FETCH_PERF_EN`)

## Operation
- State: `pc` register, FIFO (`DEPTH` × {data, pc}), occupancy `count`, one-bit `inflight` flag with its captured PC.
- Credit rule: `imem_req` = reset deasserted AND `redirect_valid`=0 AND (`count` + `inflight`) < `DEPTH`. A pop in the same cycle does not free credit.
- `imem_addr` = `pc` at all times. On an issued request, `pc` ← `pc`+4 (wraps modulo 2^ADDR_W) and `inflight` ← 1 with the request PC. With no request, `inflight` ← 0.
- When `inflight`=1, `imem_rdata` and the captured PC are written at the FIFO tail at the end of that cycle.
- Pop: `inst_valid` = (`count`≠0) AND `redirect_valid`=0. A handshake (`inst_valid`&`inst_ready`) advances the head. Simultaneous push and pop leave `count` unchanged.
- Redirect (`redirect_valid`=1):
  - `count` ← 0 and `inflight` ← 0; the pending response is discarded.
  - `pc` ← `redirect_pc`.
  - No request and no handshake occur in that cycle.
- Output values:
  - `inst_data`/`inst_pc` show the head entry whenever `count`≠0.
  - When the FIFO is empty they are don't-care.
- Reset (async, any time):
  - `pc`←`RESET_PC`; `count`, `inflight`, head pointer, and tail pointer ←0; FIFO storage ←0.
  - Outputs during reset: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `bubble_count`=0.
  - A response in flight when reset asserts is dropped.

## Timing
- Request in cycle t → word captured at end of t+1 → `inst_valid` in t+2. Fetch-to-consume latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle with `inst_ready` held high.
- After reset deasserts, the first request (`RESET_PC`) is issued in cycle 1 and the first `inst_valid` appears in cycle 3.
- With a redirect in cycle r: request at `redirect_pc` in r+1, `inst_valid` in r+3.
- Full FIFO: `imem_req` drops once `count`+`inflight`=`DEPTH`. It rises again the cycle after a pop lowers `count`.
- Redirect has priority over push, pop, and request in the same cycle.

## Configuration
- `FETCH_PERF_EN` defined:
  - `bubble_count` increments in every non-reset cycle with `inst_ready`=1 and `inst_valid`=0.
  - The counter saturates at 2^32−1 and resets to 0.
- `FETCH_PERF_EN` undefined: the `bubble_count` port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset release, ROM word at address a = 0x1000_0000 + a/4, `inst_ready`=1:
  - `imem_addr` runs 0, 4, 8, …
  - `inst_valid` goes high in cycle 3 with pc 0 / data 0x1000_0000, then one entry per cycle in order.
- Backpressure: `inst_ready`=0 from reset:
  - Exactly 4 requests (0x0–0xC) are issued, then `imem_req`=0 and `count`=4.
  - After raising `inst_ready`, entries drain pc 0, 4, 8, C in order and requests resume at 0x10.
- Redirect to 0x100 with 3 entries queued and one in flight:
  - Next cycle `inst_valid`=0 and the in-flight word never appears.
  - `imem_addr`=0x100 in r+1; first `inst_pc`=0x100 in r+3.
- Redirect in the same cycle as `inst_ready`=1 with a non-empty FIFO: `inst_valid`=0 that cycle, no entry is consumed, and the head after restart is `redirect_pc`.
- Asynchronous `reset` low between clock edges mid-stream:
  - Immediately `inst_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - On release, fetch restarts at `RESET_PC` with the first valid in cycle 3.
- With `FETCH_PERF_EN`, `inst_ready`=1 throughout:
  - `bubble_count`=2 when the first instruction is valid after reset.
  - Each subsequent redirect adds exactly 3.
